// File: rtl/dl_cycle_reporter.sv
// -----------------------------------------------------------------------------
// dl_cycle_reporter
//
// Purpose:
//   Collects the per-process cycle-detected flags from the dataflow deadlock
//   detect units and picks one process (the lowest flagged index) as the
//   token origin. The detection must stay put for CONFIRM_CYCLES cycles
//   before it is treated as a real deadlock. Once it is confirmed, the block
//   broadcasts dl_detect_out and offers one report record on a valid/ready
//   port. After the record is taken, the block stays latched until reset.
//
// Ports:
//   dl_clock       in   single clock, rising edge
//   dl_reset       in   asynchronous active-low reset
//   dl_in_vec      in   [N_PROC]  per-process cycle-detected flags
//   all_finish     in   design-under-test completed; masks every flag
//   trans_in_cnt   in   [CNT_W]   start count of the tracked process
//   trans_out_cnt  in   [CNT_W]   done count of the tracked process
//   dl_detect_out  out  confirmed-deadlock flag (REPORT and LATCHED)
//   origin         out  [N_PROC]  one-hot token-origin select
//   token_clear    out  one-cycle pulse that clears circulating tokens
//   rpt_valid      out  report record valid
//   rpt_ready      in   report consumer accept
//   rpt_proc       out  [PIDX_W]  index of the originating process
//   rpt_pending    out  [CNT_W]   outstanding transactions at confirmation
//   rpt_cycle      out  [32]      cycle-counter timestamp of confirmation
//   dbg_state      out  [2]       FSM state (0 IDLE, 1 CONFIRM, 2 REPORT,
//                                 3 LATCHED)
//   dbg_vec_m      out  [N_PROC]  effective (finish-masked) flag vector
//
// Report handshake:
//   rpt_valid is high for the whole REPORT state. The record (rpt_proc,
//   rpt_pending, rpt_cycle) is captured on entry to REPORT and holds steady.
//   A transfer happens on a rising edge where rpt_valid and rpt_ready are
//   both 1. rpt_valid never drops before that transfer. rpt_ready has no
//   effect in any other state.
// -----------------------------------------------------------------------------
module dl_cycle_reporter #(
  parameter int N_PROC         = 3,
  parameter int PIDX_W         = 2,
  parameter int CNT_W          = 16,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [N_PROC-1:0]   dl_in_vec,
  input  logic                all_finish,
  input  logic [CNT_W-1:0]    trans_in_cnt,
  input  logic [CNT_W-1:0]    trans_out_cnt,
  output logic                dl_detect_out,
  output logic [N_PROC-1:0]   origin,
  output logic                token_clear,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [PIDX_W-1:0]   rpt_proc,
  output logic [CNT_W-1:0]    rpt_pending,
  output logic [31:0]         rpt_cycle,
  output logic [1:0]          dbg_state,
  output logic [N_PROC-1:0]   dbg_vec_m
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_REPORT  = 2'd2,
    S_LATCHED = 2'd3
  } state_t;

  localparam logic [7:0] CONFIRM_LIMIT = 8'(CONFIRM_CYCLES);

  state_t              state_q, state_d;
  logic [PIDX_W-1:0]   sel_q, sel_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         cyc_q;
  logic [PIDX_W-1:0]   proc_q, proc_d;
  logic [CNT_W-1:0]    pend_q, pend_d;
  logic [31:0]         rcyc_q, rcyc_d;

  logic [N_PROC-1:0]   vec_m;
  logic [PIDX_W-1:0]   low_idx;
  logic [N_PROC-1:0]   sel_oh;
  logic                sel_hit;
  logic [7:0]          cnt_inc;

  // Once the design under test has finished, no flag can count as a cycle.
  assign vec_m = dl_in_vec & {N_PROC{~all_finish}};

  // Lowest set index. The loop runs from the top down, so the lowest
  // hit is written last and wins.
  always_comb begin
    low_idx = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (vec_m[i]) begin
        low_idx = PIDX_W'(i);
      end
    end
  end

  // A one-hot mask avoids indexing vec_m with a select wider than needed.
  assign sel_oh  = N_PROC'(1) << sel_q;
  assign sel_hit = |(vec_m & sel_oh);
  assign cnt_inc = cnt_q + 8'd1;

  // Free-running timestamp. It only wraps, and it has no other control.
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  // State and record registers
  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= 8'd0;
      proc_q  <= '0;
      pend_q  <= '0;
      rcyc_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      proc_q  <= proc_d;
      pend_q  <= pend_d;
      rcyc_q  <= rcyc_d;
    end
  end

  // Next state and outputs. origin and token_clear depend on the current
  // vec_m while in CONFIRM. This lets a dropped flag clear origin in the
  // same cycle as the token_clear pulse.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    proc_d        = proc_q;
    pend_d        = pend_q;
    rcyc_d        = rcyc_q;
    origin        = '0;
    token_clear   = 1'b0;
    dl_detect_out = 1'b0;
    rpt_valid     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|vec_m) begin
          sel_d   = low_idx;
          cnt_d   = 8'd0;
          state_d = S_CONFIRM;
        end
      end

      S_CONFIRM: begin
        // vec_m already carries the all_finish mask. Testing all_finish
        // here as well keeps its priority clear to the reader.
        if (all_finish || !sel_hit) begin
          token_clear = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_IDLE;
        end else begin
          origin = sel_oh;
          cnt_d  = cnt_inc;
          if (cnt_inc == CONFIRM_LIMIT) begin
            state_d = S_REPORT;
            proc_d  = sel_q;
            pend_d  = trans_in_cnt - trans_out_cnt;
            rcyc_d  = cyc_q;
          end
        end
      end

      S_REPORT: begin
        origin        = sel_oh;
        dl_detect_out = 1'b1;
        rpt_valid     = 1'b1;
        if (rpt_ready) begin
          state_d = S_LATCHED;
        end
      end

      S_LATCHED: begin
        origin        = sel_oh;
        dl_detect_out = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rpt_proc    = proc_q;
  assign rpt_pending = pend_q;
  assign rpt_cycle   = rcyc_q;
  assign dbg_state   = state_q;
  assign dbg_vec_m   = vec_m;

endmodule

// File: tb/tb_dl_cycle_reporter.sv
// -----------------------------------------------------------------------------
// tb_dl_cycle_reporter
//
// Directed bench for dl_cycle_reporter with default parameters
// (N_PROC=3, PIDX_W=2, CNT_W=16, CONFIRM_CYCLES=4).
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled on
// the falling edge. Each record holds the inputs for one cycle and the
// outputs expected in that same cycle. The state is the one in effect
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_dl_cycle_reporter;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;
  localparam logic [1:0] ST_LATCHED = 2'd3;

  typedef struct {
    logic [2:0]  vec;
    logic        fin;
    logic [15:0] tin;
    logic [15:0] tout;
    logic        rdy;
    logic [1:0]  e_st;
    logic [2:0]  e_org;
    logic        e_clr;
    logic [1:0]  e_proc;
    logic [15:0] e_pend;
    logic [31:0] e_cyc;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        dl_clock = 1'b0;
  logic        dl_reset = 1'b0;
  logic [2:0]  dl_in_vec = '0;
  logic        all_finish = 1'b0;
  logic [15:0] trans_in_cnt = '0;
  logic [15:0] trans_out_cnt = '0;
  logic        rpt_ready = 1'b0;
  logic        dl_detect_out;
  logic [2:0]  origin;
  logic        token_clear;
  logic        rpt_valid;
  logic [1:0]  rpt_proc;
  logic [15:0] rpt_pending;
  logic [31:0] rpt_cycle;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_vec_m;

  int checks   = 0;
  int failures = 0;

  always #5 dl_clock = ~dl_clock;

  dl_cycle_reporter #(
    .N_PROC(3), .PIDX_W(2), .CNT_W(16), .CONFIRM_CYCLES(4)
  ) dut (
    .dl_clock      (dl_clock),
    .dl_reset      (dl_reset),
    .dl_in_vec     (dl_in_vec),
    .all_finish    (all_finish),
    .trans_in_cnt  (trans_in_cnt),
    .trans_out_cnt (trans_out_cnt),
    .dl_detect_out (dl_detect_out),
    .origin        (origin),
    .token_clear   (token_clear),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .rpt_proc      (rpt_proc),
    .rpt_pending   (rpt_pending),
    .rpt_cycle     (rpt_cycle),
    .dbg_state     (dbg_state),
    .dbg_vec_m     (dbg_vec_m)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] vec, input logic fin,
                              input logic [15:0] tin, input logic [15:0] tout,
                              input logic rdy, input logic [1:0] st,
                              input logic [2:0] org, input logic clr,
                              input logic [1:0] proc, input logic [15:0] pend,
                              input logic [31:0] cyc);
    vec_t r;
    r.vec = vec; r.fin = fin; r.tin = tin; r.tout = tout; r.rdy = rdy;
    r.e_st = st; r.e_org = org; r.e_clr = clr;
    r.e_proc = proc; r.e_pend = pend; r.e_cyc = cyc;
    return r;
  endfunction

  task automatic check_all(input string tag, input vec_t r);
    logic       e_det;
    logic       e_val;
    logic [2:0] e_vm;
    e_det = (r.e_st == ST_REPORT) || (r.e_st == ST_LATCHED);
    e_val = (r.e_st == ST_REPORT);
    e_vm  = r.fin ? 3'b000 : r.vec;
    chk({tag, " state"},   32'(dbg_state),     32'(r.e_st));
    chk({tag, " detect"},  32'(dl_detect_out), 32'(e_det));
    chk({tag, " origin"},  32'(origin),        32'(r.e_org));
    chk({tag, " clear"},   32'(token_clear),   32'(r.e_clr));
    chk({tag, " valid"},   32'(rpt_valid),     32'(e_val));
    chk({tag, " proc"},    32'(rpt_proc),      32'(r.e_proc));
    chk({tag, " pending"}, 32'(rpt_pending),   32'(r.e_pend));
    chk({tag, " cycle"},   rpt_cycle,          r.e_cyc);
    chk({tag, " vec_m"},   32'(dbg_vec_m),     32'(e_vm));
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive, sample on falling edge, advance past the rising edge.
  task automatic step(input string tag, input vec_t r);
    dl_in_vec     = r.vec;
    all_finish    = r.fin;
    trans_in_cnt  = r.tin;
    trans_out_cnt = r.tout;
    rpt_ready     = r.rdy;
    @(negedge dl_clock);
    check_all(tag, r);
    @(posedge dl_clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " state"},   32'(dbg_state),     32'd0);
    chk({tag, " detect"},  32'(dl_detect_out), 32'd0);
    chk({tag, " origin"},  32'(origin),        32'd0);
    chk({tag, " clear"},   32'(token_clear),   32'd0);
    chk({tag, " valid"},   32'(rpt_valid),     32'd0);
    chk({tag, " proc"},    32'(rpt_proc),      32'd0);
    chk({tag, " pending"}, 32'(rpt_pending),   32'd0);
    chk({tag, " cycle"},   rpt_cycle,          32'd0);
  endtask

  // Called 1 unit after a rising edge. Reset is asserted between edges, so
  // zero outputs here show the reset acting without a clock edge. Release
  // also happens 1 unit after a rising edge.
  task automatic do_reset(input string tag);
    dl_reset = 1'b0;
    #1;
    check_zero({tag, " async"});
    repeat (2) @(posedge dl_clock);
    #1;
    check_zero({tag, " held"});
    dl_reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[8];

  initial begin
    // Main confirm-and-report run: vec=110, trans 7/5, ready held high.
    tbl[0] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_IDLE,    3'b000, 0, 2'd0, 16'd0, 32'd0);
    tbl[1] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_CONFIRM, 3'b010, 0, 2'd0, 16'd0, 32'd0);
    tbl[2] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_CONFIRM, 3'b010, 0, 2'd0, 16'd0, 32'd0);
    tbl[3] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_CONFIRM, 3'b010, 0, 2'd0, 16'd0, 32'd0);
    tbl[4] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_CONFIRM, 3'b010, 0, 2'd0, 16'd0, 32'd0);
    tbl[5] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_REPORT,  3'b010, 0, 2'd1, 16'd2, 32'd4);
    tbl[6] = mk(3'b110, 0, 16'd7, 16'd5, 1, ST_LATCHED, 3'b010, 0, 2'd1, 16'd2, 32'd4);
    tbl[7] = mk(3'b000, 1, 16'd9, 16'd1, 1, ST_LATCHED, 3'b010, 0, 2'd1, 16'd2, 32'd4);

    // Outputs must be zero while reset is held from time 0.
    #2;
    check_zero("por");
    @(posedge dl_clock);
    #1;
    do_reset("rst0");
    for (int i = 0; i < 8; i++) step($sformatf("main[%0d]", i), tbl[i]);

    // Flag drops after 2 cycles. Then re-arbitrate from the lowest index.
    do_reset("rst1");
    step("drop[0]", mk(3'b001, 0, 0, 0, 0, ST_IDLE,    3'b000, 0, 0, 0, 0));
    step("drop[1]", mk(3'b001, 0, 0, 0, 0, ST_CONFIRM, 3'b001, 0, 0, 0, 0));
    step("drop[2]", mk(3'b000, 0, 0, 0, 0, ST_CONFIRM, 3'b000, 1, 0, 0, 0));
    step("drop[3]", mk(3'b000, 0, 0, 0, 0, ST_IDLE,    3'b000, 0, 0, 0, 0));
    step("rearb[0]", mk(3'b110, 0, 0, 0, 0, ST_IDLE,    3'b000, 0, 0, 0, 0));
    step("rearb[1]", mk(3'b110, 0, 0, 0, 0, ST_CONFIRM, 3'b010, 0, 0, 0, 0));
    step("rearb[2]", mk(3'b000, 0, 0, 0, 0, ST_CONFIRM, 3'b000, 1, 0, 0, 0));
    step("rearb[3]", mk(3'b000, 0, 0, 0, 0, ST_IDLE,    3'b000, 0, 0, 0, 0));

    // all_finish rises in the 2nd CONFIRM cycle. The flag is masked from then on.
    do_reset("rst2");
    step("fin[0]", mk(3'b011, 0, 0, 0, 0, ST_IDLE,    3'b000, 0, 0, 0, 0));
    step("fin[1]", mk(3'b011, 0, 0, 0, 0, ST_CONFIRM, 3'b001, 0, 0, 0, 0));
    step("fin[2]", mk(3'b011, 1, 0, 0, 0, ST_CONFIRM, 3'b000, 1, 0, 0, 0));
    for (int i = 3; i < 8; i++)
      step($sformatf("fin[%0d]", i), mk(3'b011, 1, 0, 0, 0, ST_IDLE, 3'b000, 0, 0, 0, 0));

    // Backpressure on the report, plus wrapped pending count (1 - FFFF = 2).
    // Ready is high before REPORT and must be ignored there.
    do_reset("rst3");
    step("bp_idle", mk(3'b100, 0, 16'h0001, 16'hFFFF, 1, ST_IDLE, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step($sformatf("bp_conf[%0d]", i),
           mk(3'b100, 0, 16'h0001, 16'hFFFF, (i < 3), ST_CONFIRM, 3'b100, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      step($sformatf("bp_wait[%0d]", i),
           mk(3'b100, 0, 16'h0100 + 16'(i), 16'h0003, 0, ST_REPORT, 3'b100, 0, 2'd2, 16'h0002, 32'd4));
    step("bp_accept", mk(3'b100, 0, 16'h0055, 16'h0003, 1, ST_REPORT,  3'b100, 0, 2'd2, 16'h0002, 32'd4));
    step("bp_latch",  mk(3'b100, 0, 16'h0055, 16'h0003, 0, ST_LATCHED, 3'b100, 0, 2'd2, 16'h0002, 32'd4));
    for (int i = 0; i < 3; i++)
      step($sformatf("bp_hold[%0d]", i),
           mk(3'b000, 0, 16'h0000, 16'h0000, 1, ST_LATCHED, 3'b100, 0, 2'd2, 16'h0002, 32'd4));

    // Reset in the middle of REPORT. The record is discarded without a
    // handshake, and the next report is timestamped from zero again.
    do_reset("rst4");
    step("mr_idle", mk(3'b001, 0, 16'd9, 16'd4, 0, ST_IDLE, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step($sformatf("mr_conf[%0d]", i), mk(3'b001, 0, 16'd9, 16'd4, 0, ST_CONFIRM, 3'b001, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("mr_rep[%0d]", i), mk(3'b001, 0, 16'd9, 16'd4, 0, ST_REPORT, 3'b001, 0, 0, 16'd5, 32'd4));
    do_reset("rst_mid");
    step("mr2_idle", mk(3'b001, 0, 16'd9, 16'd4, 0, ST_IDLE, 3'b000, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step($sformatf("mr2_conf[%0d]", i), mk(3'b001, 0, 16'd9, 16'd4, 0, ST_CONFIRM, 3'b001, 0, 0, 0, 0));
    step("mr2_rep",   mk(3'b001, 0, 16'd9, 16'd4, 1, ST_REPORT,  3'b001, 0, 0, 16'd5, 32'd4));
    step("mr2_latch", mk(3'b001, 0, 16'd9, 16'd4, 0, ST_LATCHED, 3'b001, 0, 0, 16'd5, 32'd4));

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dl_cycle_reporter.md
DL_CYCLE_REPORTER -- requirements
Module: dl_cycle_reporter

Interface
REQ-001: Parameter N_PROC, default 3, SHALL set the number of monitored dataflow processes.
REQ-002: Parameter PIDX_W, default 2, SHALL set the width of the process index; ceil(log2(N_PROC)) <= PIDX_W.
REQ-003: Parameter CNT_W, default 16, SHALL set the width of the transaction counters.
REQ-004: Parameter CONFIRM_CYCLES, default 4, range 1..255, SHALL set the number of cycles a candidate detection must persist before it is reported.
REQ-005: dl_clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006: dl_reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-007: dl_in_vec  in  N_PROC  SHALL carry the per-process cycle-detected flags from the per-process detect units.
REQ-008: all_finish  in  1  SHALL indicate that the design under test has completed.
REQ-009: trans_in_cnt  in  CNT_W  SHALL carry the start count of the dataflow process under transaction tracking.
REQ-010: trans_out_cnt  in  CNT_W  SHALL carry the done count of the same process.
REQ-011: dl_detect_out  out  1  SHALL be the confirmed-deadlock flag, broadcast to all detect units.
REQ-012: origin  out  N_PROC  SHALL be the one-hot token-origin select.
REQ-013: token_clear  out  1  SHALL be a one-cycle pulse that clears all circulating tokens.
REQ-014: rpt_valid  out  1  SHALL mark a valid deadlock report record.
REQ-015: rpt_ready  in  1  SHALL be the report consumer's accept signal.
REQ-016: rpt_proc  out  PIDX_W  SHALL give the index of the originating process.
REQ-017: rpt_pending  out  CNT_W  SHALL give the outstanding transaction count.
REQ-018: rpt_cycle  out  32  SHALL give the timestamp of the confirmation.

Function
REQ-019: The block SHALL mask dl_in_vec with ~all_finish on every bit to form the effective vector vec_m.
REQ-020: A 32-bit free-running cycle counter SHALL increment every cycle, wrap from 0xFFFFFFFF to 0, and hold no other state.
REQ-021: The FSM SHALL use exactly these states: IDLE, CONFIRM, REPORT, LATCHED.
REQ-022: In IDLE with vec_m == 0, the FSM SHALL remain in IDLE with origin = 0.
REQ-023: In IDLE with vec_m != 0, the FSM SHALL register sel = the lowest set index, drive origin = one-hot(sel) from the next cycle, clear the confirm counter, and enter CONFIRM.
REQ-024: In CONFIRM, origin SHALL hold one-hot(sel).
REQ-025: In CONFIRM, while vec_m[sel] = 1, the confirm counter SHALL increment once per cycle.
REQ-026: In CONFIRM, when vec_m[sel] = 0, the FSM SHALL assert token_clear for exactly one cycle, drive origin = 0, and return to IDLE.
REQ-027: In CONFIRM, when the confirm counter reaches CONFIRM_CYCLES with vec_m[sel] still 1, the FSM SHALL enter REPORT.
REQ-028: On the transition into REPORT, the block SHALL latch rpt_proc = sel, rpt_pending = (trans_in_cnt - trans_out_cnt) mod 2^CNT_W, and rpt_cycle = the cycle counter value.
REQ-029: In REPORT and LATCHED, dl_detect_out SHALL be 1 and origin SHALL hold one-hot(sel).
REQ-030: In REPORT, rpt_valid SHALL be 1, and the record SHALL stay stable until the cycle in which rpt_ready = 1.
REQ-031: In REPORT, after the accepting cycle, the FSM SHALL enter LATCHED with rpt_valid = 0.
REQ-032: LATCHED SHALL be terminal until reset; changes on dl_in_vec and all_finish SHALL be ignored there.
REQ-033: In CONFIRM, all_finish = 1 SHALL take priority over confirmation: token_clear pulses for one cycle and the FSM returns to IDLE.
REQ-034: rpt_ready = 1 outside REPORT SHALL have no effect.
REQ-035: token_clear SHALL never be asserted in IDLE, REPORT or LATCHED except as the single pulse defined in REQ-026 and REQ-033.
REQ-036: After any return to IDLE, a new detection SHALL re-arbitrate from the lowest index.

Reset
REQ-037: On dl_reset = 0, the block SHALL asynchronously force state = IDLE, the cycle counter = 0, and the confirm counter = 0.
REQ-038: On dl_reset = 0, all outputs SHALL be forced to 0: dl_detect_out, origin, token_clear, rpt_valid, rpt_proc, rpt_pending, rpt_cycle.
REQ-039: Reset asserted in any state, including mid-REPORT, SHALL discard the pending report without a handshake.
REQ-040: Release of reset SHALL take effect on the first rising edge of dl_clock with dl_reset = 1.

Verification
REQ-041: dl_in_vec = 3'b110 held, CONFIRM_CYCLES = 4, trans_in = 7, trans_out = 5, rpt_ready = 1 -> origin = 3'b010 next cycle; dl_detect_out = 1 and rpt_valid = 1 after 4 further cycles with rpt_proc = 1 and rpt_pending = 2; rpt_valid = 0 one cycle later.
REQ-042: dl_in_vec = 3'b001 for 2 cycles, then 0 -> token_clear = 1 for exactly one cycle, origin = 0, dl_detect_out never asserted.
REQ-043: Detection held and all_finish = 1 asserted in the 2nd CONFIRM cycle -> token_clear pulse, return to IDLE, no report; the bench must also check vec_m = 0 thereafter.
REQ-044: Confirmed detection with rpt_ready = 0 for 10 cycles -> rpt_valid and the record stay stable; one cycle with rpt_ready = 1 moves the FSM to LATCHED; dl_detect_out stays 1 through later dl_in_vec = 0.
REQ-045: trans_in = 0x0001, trans_out = 0xFFFF at confirmation -> rpt_pending = 0x0002 (wrap).
REQ-046: dl_reset pulsed low mid-REPORT -> all outputs 0 immediately (asynchronously); after release, a fresh detection is reported with rpt_cycle counted from 0.
